// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 window interface: pixel/window widths,
// counter width and tap slice positions of the packed window.
package conv_pkg;

    localparam int DATA_W = 16;
    localparam int WIN_W  = 9 * DATA_W;
    localparam int CNT_W  = 7;

    // Tap rc: r = window row (1 oldest line), c = window column (1 oldest pixel)
    localparam int TAP11_MSB = 143;
    localparam int TAP11_LSB = 128;
    localparam int TAP12_MSB = 127;
    localparam int TAP12_LSB = 112;
    localparam int TAP13_MSB = 111;
    localparam int TAP13_LSB = 96;
    localparam int TAP21_MSB = 95;
    localparam int TAP21_LSB = 80;
    localparam int TAP22_MSB = 79;
    localparam int TAP22_LSB = 64;
    localparam int TAP23_MSB = 63;
    localparam int TAP23_LSB = 48;
    localparam int TAP31_MSB = 47;
    localparam int TAP31_LSB = 32;
    localparam int TAP32_MSB = 31;
    localparam int TAP32_LSB = 16;
    localparam int TAP33_MSB = 15;
    localparam int TAP33_LSB = 0;

endpackage

// File: rtl/line_buffer_sr.sv
// Enabled shift-register line buffer; dout is the sample shifted in DEPTH
// enables ago.
module line_buffer_sr #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else if (en) begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_window_gen_3x3.sv
// Raster stream to 3x3 window generator (valid-only, no padding) feeding the
// convolution core with packed windows and output coordinates.
module conv_window_gen_3x3 #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_vsync,
    input  logic                         pix_href,
    input  logic [DATA_W-1:0]            pix_data,
    output logic                         matrix_vsync,
    output logic                         matrix_href,
    output logic [conv_pkg::CNT_W-1:0]   matrix_h_cnt,
    output logic [conv_pkg::CNT_W-1:0]   matrix_v_cnt,
    output logic [9*DATA_W-1:0]          fm_data
);

    import conv_pkg::*;

    logic [CNT_W-1:0]  in_x;
    logic [CNT_W-1:0]  in_y;
    logic              accept;
    logic [DATA_W-1:0] tap_y1;
    logic [DATA_W-1:0] tap_y2;
    logic [DATA_W-1:0] win [3][3];

    assign accept = pix_href && pix_vsync && (in_y < CNT_W'(IMG_HEIGHT));

    line_buffer_sr #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (pix_data),
        .dout (tap_y1)
    );

    line_buffer_sr #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (tap_y1),
        .dout (tap_y2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_x         <= '0;
            in_y         <= '0;
            matrix_vsync <= 1'b0;
            matrix_href  <= 1'b0;
            matrix_h_cnt <= '0;
            matrix_v_cnt <= '0;
        end else begin
            matrix_vsync <= pix_vsync;
            matrix_href  <= accept && (in_x >= CNT_W'(2)) && (in_y >= CNT_W'(2));
            if (!pix_vsync) begin
                in_x <= '0;
                in_y <= '0;
            end else if (accept) begin
                if (in_x == CNT_W'(IMG_WIDTH - 1)) begin
                    in_x <= '0;
                    in_y <= in_y + CNT_W'(1);
                end else begin
                    in_x <= in_x + CNT_W'(1);
                end
            end
            if (accept) begin
                matrix_h_cnt <= in_x - CNT_W'(2);
                matrix_v_cnt <= in_y - CNT_W'(2);
            end
        end
    end

    // Window registers double as the fm_data output register: column 0 oldest
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= tap_y2;
            win[1][2] <= tap_y1;
            win[2][2] <= pix_data;
        end
    end

    always_comb begin
        fm_data = '0;
        fm_data[TAP11_MSB:TAP11_LSB] = win[0][0];
        fm_data[TAP12_MSB:TAP12_LSB] = win[0][1];
        fm_data[TAP13_MSB:TAP13_LSB] = win[0][2];
        fm_data[TAP21_MSB:TAP21_LSB] = win[1][0];
        fm_data[TAP22_MSB:TAP22_LSB] = win[1][1];
        fm_data[TAP23_MSB:TAP23_LSB] = win[1][2];
        fm_data[TAP31_MSB:TAP31_LSB] = win[2][0];
        fm_data[TAP32_MSB:TAP32_LSB] = win[2][1];
        fm_data[TAP33_MSB:TAP33_LSB] = win[2][2];
    end

endmodule
